// File: rtl/lsu_agu_if.sv
// Data-memory bus between the load/store unit (master) and the memory mux (slave).
// Word-aligned address, separate read/write strobes, byte enables and lane data.
interface lsu_agu_if #(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 14
);
    logic [ADDR_LEN-1:0] addr;
    logic                rd_req;
    logic                rd_ready;
    logic                wr_req;
    logic                wr_ready;
    logic [XLEN/8-1:0]   wr_be;
    logic [XLEN-1:0]     wr_data;
    logic [XLEN-1:0]     rd_data;

    modport master (
        output addr,
        output rd_req,
        output wr_req,
        output wr_be,
        output wr_data,
        input  rd_ready,
        input  wr_ready,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  rd_req,
        input  wr_req,
        input  wr_be,
        input  wr_data,
        output rd_ready,
        output wr_ready,
        output rd_data
    );
endinterface

// File: rtl/lsu_agu.sv
// RISC-V load/store address-generation unit: one bus access and one response per request.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module lsu_agu #(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 14,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    lsu_agu_if.master           bus
);
    localparam int              BW       = XLEN / 8;
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic                cap_we_q, cap_we_d;
    logic [2:0]          cap_funct3_q, cap_funct3_d;
    logic [1:0]          cap_off_q, cap_off_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [BW-1:0]       wr_be_q, wr_be_d;
    logic [XLEN-1:0]     wr_data_q, wr_data_d;
    logic                resp_err_q, resp_err_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;

    logic                req_illegal;
    logic                req_misaligned;
    logic                req_bad;
    logic [1:0]          req_off;
    logic [BW-1:0]       st_be;
    logic [XLEN-1:0]     st_data;
    logic [XLEN-1:0]     ld_shift;
    logic [XLEN-1:0]     ld_data;

    always_comb begin : req_decode
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
            3'b100, 3'b101:         req_illegal = req_we;
            default:                req_illegal = 1'b1;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        req_off        = req_addr[1:0];
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        // Without the trap, offset bits finer than the access size are simply dropped.
        req_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_off = {req_addr[1], 1'b0};
            2'b10:   req_off = 2'b00;
            default: req_off = req_addr[1:0];
        endcase
`endif
        req_bad = req_illegal | req_misaligned;
    end

    always_comb begin : store_lanes
        case (req_funct3[1:0])
            2'b00: begin
                st_data = {4{req_wdata[7:0]}};
                st_be   = 4'b0001 << req_off;
            end
            2'b01: begin
                st_data = {2{req_wdata[15:0]}};
                st_be   = 4'b0011 << {req_off[1], 1'b0};
            end
            default: begin
                st_data = req_wdata;
                st_be   = '1;
            end
        endcase
    end

    always_comb begin : load_extract
        ld_shift = bus.rd_data >> {cap_off_q, 3'b000};
        case (cap_funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin : fsm_state
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (cap_we_q) begin
                    if (bus.wr_ready) begin
                        state_d = RESP;
                    end
                end else begin
                    state_d = bus.rd_ready ? RESP : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bus.rd_ready || (tmo_cnt_q == TMO_LAST)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : fsm_out
        req_ready  = (state_q == IDLE);
        bus.rd_req = (state_q == ISSUE) && !cap_we_q;
        bus.wr_req = (state_q == ISSUE) && cap_we_q;
        resp_valid = (state_q == RESP);
    end

    always_comb begin : datapath_next
        // NOTE: every _d starts as its _q so no branch leaves one unassigned and infers a latch.
        cap_we_d     = cap_we_q;
        cap_funct3_d = cap_funct3_q;
        cap_off_d    = cap_off_q;
        addr_d       = addr_q;
        wr_be_d      = wr_be_q;
        wr_data_d    = wr_data_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        tmo_cnt_d    = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cap_we_d     = req_we;
                    cap_funct3_d = req_funct3;
                    cap_off_d    = req_off;
                    if (req_bad) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        addr_d = {req_addr[ADDR_LEN-1:2], 2'b00};
                        if (req_we) begin
                            wr_be_d   = st_be;
                            wr_data_d = st_data;
                        end
                    end
                end
            end
            ISSUE: begin
                if (cap_we_q) begin
                    if (bus.wr_ready) begin
                        wr_be_d      = '0;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = '0;
                    end
                end else if (bus.rd_ready) begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = ld_data;
                end else begin
                    tmo_cnt_d = '0;
                end
            end
            WAIT_RD: begin
                if (bus.rd_ready) begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = ld_data;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            RESP: begin
                // Response fields are only meaningful while resp_valid is high.
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rstb) begin : datapath_regs
        if (!rstb) begin
            cap_we_q     <= 1'b0;
            cap_funct3_q <= '0;
            cap_off_q    <= '0;
            addr_q       <= '0;
            wr_be_q      <= '0;
            wr_data_q    <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            cap_we_q     <= cap_we_d;
            cap_funct3_q <= cap_funct3_d;
            cap_off_q    <= cap_off_d;
            addr_q       <= addr_d;
            wr_be_q      <= wr_be_d;
            wr_data_q    <= wr_data_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign bus.addr    = addr_q;
    assign bus.wr_be   = wr_be_q;
    assign bus.wr_data = wr_data_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;

endmodule

// File: doc/lsu_agu.md
Name: lsu_agu

Overview:
- Load/store unit between the core execute stage and the data-memory mux; feeds the mux's addr/rd_req/wr_req/wr_be/wr_data interface and consumes rd_data/rd_ready.
- Converts a RISC-V load/store (funct3 encoded) into a word-aligned bus access with byte enables and lane-replicated write data.
- Extracts, shifts and sign/zero-extends load data, and returns one response per request, with a read timeout.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- ADDR_LEN, 14, byte-address width.
- TIMEOUT, 16, maximum WAIT_RD cycles before an error response; must be >= 2.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  high in IDLE only
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use 000/001/010)
- req_addr  in  ADDR_LEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal funct3 or timeout
- addr  out  ADDR_LEN  bus address, low 2 bits always 0
- rd_req  out  1  read strobe
- rd_ready  in  1  read data valid
- wr_req  out  1  write strobe
- wr_ready  in  1  write accepted
- wr_be  out  XLEN/8  byte enables
- wr_data  out  XLEN  lane-replicated write data
- rd_data  in  XLEN  read data

Behaviour:
- Reset: rstb is asynchronous and active-low; clock is clk.
  - While rstb is low: state IDLE; addr, wr_be, wr_data, resp_rdata all 0; rd_req, wr_req, resp_valid, resp_err all 0; req_ready 1 (decoded from state IDLE).
- FSM states: IDLE, ISSUE, WAIT_RD, RESP. All outputs are registered or decoded from state.
- IDLE:
  - On req_valid & req_ready, capture we, funct3, addr and wdata.
  - Go to ISSUE; go directly to RESP with err=1 if funct3 is illegal (011, 110, 111, or 1xx with we=1), or if the access is misaligned (see Optional Feature).
- ISSUE:
  - addr = {cap_addr[ADDR_LEN-1:2], 2'b00}.
  - Load: rd_req=1 for exactly this cycle. If rd_ready is already high, capture data and go to RESP; otherwise go to WAIT_RD.
  - Store: wr_req=1 and wr_be/wr_data valid. If wr_ready, go to RESP; otherwise stay in ISSUE and hold all outputs.
- WAIT_RD:
  - rd_req=0; addr is held stable.
  - Timeout counter, width $clog2(TIMEOUT+1), is cleared on entry and increments each cycle without rd_ready.
  - rd_ready: capture the extended data and go to RESP.
  - Counter == TIMEOUT-1 with no rd_ready: go to RESP with err=1 and rdata=0.
- RESP: resp_valid=1 for one cycle, then return to IDLE. The core may not stall a response.
- Write lane rules (off = cap_addr[1:0]):
  - SB: data = {4{wdata[7:0]}}, be = 4'b0001 << off.
  - SH: data = {2{wdata[15:0]}}, be = 4'b0011 << {off[1], 1'b0}.
  - SW: data = wdata, be = 4'b1111.
  - wr_be = 0 whenever wr_req = 0.
- Load extraction: sh = rd_data >> (8*off).
  - LB: sign-extend sh[7:0].
  - LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0].
  - LHU: zero-extend sh[15:0].
  - LW: sh.
- Latency, with acceptance at edge T:
  - Store: wr_req in T+1, resp_valid in T+2.
  - Load with 1-cycle memory: rd_req in T+1, rd_ready in T+2, resp_valid in T+3.
- A late rd_ready arriving in IDLE or RESP after a timeout is ignored.
- Reset asserted mid-transaction returns to IDLE with no response issued.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned means halfword with off[0]=1, or word with off != 0.
- Defined: a misaligned request generates no rd_req/wr_req and goes IDLE -> RESP, so resp_valid=1 and resp_err=1 in T+1.
- Undefined: misalignment is not checked. Offset bits below the access size are forced to 0 (halfword: off[0]=0; word: off=0) and the access proceeds normally with resp_err=0.

Test Plan:
- SW 0xDEADBEEF at 0x1004 -> T+1: wr_req=1, addr=0x1004, wr_be=1111, wr_data=0xDEADBEEF; T+2: resp_valid=1, resp_err=0, resp_rdata=0.
- SB 0x5A5 at 0x1006 -> wr_be=0100, wr_data=0xA5A5A5A5; SH 0x1234 at 0x1002 -> wr_be=1100, wr_data=0x12341234.
- Memory returns 0x80123456 one cycle after rd_req:
  - LB 0x1007 -> resp_rdata 0xFFFFFF80 at T+3.
  - LBU 0x1007 -> 0x00000080.
  - LH 0x1002 -> 0xFFFF8012.
  - LHU 0x1000 -> 0x00003456.
- LW at 0x1001:
  - With LSU_MISALIGN_TRAP_EN: no rd_req, resp_valid and resp_err at T+1.
  - Without it: rd_req with addr=0x1000, resp_err=0.
- Load with rd_ready held low, TIMEOUT=16 -> resp_valid=1, resp_err=1, resp_rdata=0 at T+18; a rd_ready pulse at T+20 produces no response; req_ready=1 at T+19.
- rstb low during WAIT_RD -> all outputs 0 and req_ready=1 immediately; rd_ready afterwards produces no resp_valid; the next LW completes normally.
- Illegal funct3=011 load -> no bus access; resp_valid and resp_err at T+1.
